// File: rtl/aliens_pkg.sv
// aliens_pkg
// Shared types and constants for the Aliens control latch block.
//   coin_state_t      : coin counter stretcher FSM states (IDLE, PULSE, HOLD)
//   CTRL_ADDR_DEFAULT : default control register write address
//   WDOG_ADDR_DEFAULT : default watchdog kick address
//   is_write_cycle()  : qualifies a CPU write on the registered falling edge of as_n
package aliens_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } coin_state_t;

  localparam logic [15:0] CTRL_ADDR_DEFAULT = 16'h5F88;
  localparam logic [15:0] WDOG_ADDR_DEFAULT = 16'h5F8C;

  // A write is the first cycle of a low strobe with rw low; a held-low strobe never re-fires.
  function automatic logic is_write_cycle(input logic as_n, input logic as_n_prev, input logic rw);
    return (!as_n) && as_n_prev && (!rw);
  endfunction

endpackage

// File: rtl/aliens_ctrl_latch_if.sv
// aliens_ctrl_latch_if
// CPU-side bus into the control latch.
//   as_n    : address strobe, active-low, synchronous to clk
//   rw      : 1 = read, 0 = write
//   addr    : CPU address (16)
//   din     : CPU write data (8)
//   bank_wr : one-cycle strobe from the CPU bank-line output
//   bank_d  : ROM bank value captured on bank_wr (5)
// Modports: master drives the bus (CPU / bench), slave receives it (latch).
interface aliens_ctrl_latch_if;
  logic        as_n;
  logic        rw;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        bank_wr;
  logic [4:0]  bank_d;

  modport master (output as_n, rw, addr, din, bank_wr, bank_d);
  modport slave  (input  as_n, rw, addr, din, bank_wr, bank_d);
endinterface

// File: rtl/aliens_coin_stretch.sv
// aliens_coin_stretch
// Stretches one coin counter control bit so the electromechanical counter
// sees a pulse of at least COIN_PULSE clocks.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   clr      : synchronous abort to IDLE (watchdog bite)
//   ctrl_bit : latched control bit for this channel
//   coin     : registered counter drive
module aliens_coin_stretch
  import aliens_pkg::*;
#(
  parameter int COIN_PULSE = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic ctrl_bit,
  output logic coin
);

  localparam int CW = $clog2(COIN_PULSE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(COIN_PULSE - 1);

  coin_state_t   state_r;
  coin_state_t   state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          coin_r;

  // State, pulse counter and registered drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      coin_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      coin_r  <= (state_nxt_s != IDLE);
    end
  end

  // Next-state logic. In IDLE the bit can only be 1 after being 0 (HOLD
  // absorbs a bit that stays high), so bit==1 in IDLE is the 0->1 edge.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (clr) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_nxt_s = '0;
          if (ctrl_bit) begin
            state_nxt_s = PULSE;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        PULSE: begin
          // Pulse length is fixed; a bit cleared mid-pulse only picks the exit.
          if (cnt_r == CNT_LAST) begin
            cnt_nxt_s = '0;
            if (ctrl_bit) begin
              state_nxt_s = HOLD;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end
        HOLD: begin
          if (ctrl_bit) begin
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  assign coin = coin_r;

endmodule

// File: rtl/aliens_ctrl_latch.sv
// aliens_ctrl_latch
// Control latch for the Aliens board: CPU-written control byte, ROM bank
// register, INIT generator for the address decoder and stretched coin
// counter drives. Optional watchdog enabled by defining ALIENS_WATCHDOG_EN.
//   clk      : system clock, all state on rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : CPU bus (aliens_ctrl_latch_if.slave)
//   bk       : registered ROM bank, bk[4] -> decoder BK4
//   woco     : work/colour RAM select (ctrl_q[5])
//   rmrd     : tilemap ROM readback (ctrl_q[6])
//   init     : decoder INIT, 0 during the init window
//   coin_cnt : stretched coin counter drives
//   ctrl_q   : full latched control byte
module aliens_ctrl_latch
  import aliens_pkg::*;
#(
  parameter logic [15:0] CTRL_ADDR   = CTRL_ADDR_DEFAULT,
  parameter logic [15:0] WDOG_ADDR   = WDOG_ADDR_DEFAULT,
  parameter int          INIT_CYCLES = 1024,
  parameter int          COIN_PULSE  = 64,
  parameter int          WDOG_CYCLES = 262144
) (
  input  logic                clk,
  input  logic                rst_n,
  aliens_ctrl_latch_if.slave  bus,
  output logic [4:0]          bk,
  output logic                woco,
  output logic                rmrd,
  output logic                init,
  output logic [1:0]          coin_cnt,
  output logic [7:0]          ctrl_q
);

  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

  logic          as_n_prev_r;
  logic [7:0]    ctrl_q_r;
  logic [4:0]    bk_r;
  logic          init_r;
  logic [IW-1:0] init_cnt_r;
  logic          wr_s;
  logic          ctrl_wr_s;
  logic          bite_s;

  assign wr_s      = is_write_cycle(bus.as_n, as_n_prev_r, bus.rw);
  assign ctrl_wr_s = wr_s && (bus.addr == CTRL_ADDR);

`ifdef ALIENS_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wdog_cnt_r;
  logic          kick_s;

  assign kick_s = wr_s && (bus.addr == WDOG_ADDR);
  // A kick in the final cycle still rescues the system.
  assign bite_s = init_r && !kick_s && (wdog_cnt_r == WDOG_LAST);

  // Watchdog counter: runs only while init is high; never passes WDOG_LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_r <= '0;
    end else if (bite_s || kick_s || !init_r) begin
      wdog_cnt_r <= '0;
    end else begin
      wdog_cnt_r <= wdog_cnt_r + WW'(1);
    end
  end
`else
  assign bite_s = 1'b0;
`endif

  // Strobe edge history, control byte and bank register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      as_n_prev_r <= 1'b1;
      ctrl_q_r    <= 8'h00;
      bk_r        <= 5'h00;
    end else begin
      as_n_prev_r <= bus.as_n;
      if (bite_s) begin
        ctrl_q_r <= 8'h00;
        bk_r     <= 5'h00;
      end else begin
        if (ctrl_wr_s) begin
          ctrl_q_r <= bus.din;
        end
        if (bus.bank_wr) begin
          bk_r <= bus.bank_d;
        end
      end
    end
  end

  // INIT window: counter saturates at INIT_LAST, init rises on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_r     <= 1'b0;
      init_cnt_r <= '0;
    end else if (bite_s) begin
      init_r     <= 1'b0;
      init_cnt_r <= '0;
    end else if (!init_r) begin
      if (init_cnt_r == INIT_LAST) begin
        init_r <= 1'b1;
      end else begin
        init_cnt_r <= init_cnt_r + IW'(1);
      end
    end
  end

  aliens_coin_stretch #(.COIN_PULSE(COIN_PULSE)) u_coin0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bite_s),
    .ctrl_bit (ctrl_q_r[0]),
    .coin     (coin_cnt[0])
  );

  aliens_coin_stretch #(.COIN_PULSE(COIN_PULSE)) u_coin1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bite_s),
    .ctrl_bit (ctrl_q_r[1]),
    .coin     (coin_cnt[1])
  );

  assign ctrl_q = ctrl_q_r;
  assign woco   = ctrl_q_r[5];
  assign rmrd   = ctrl_q_r[6];
  assign bk     = bk_r;
  assign init   = init_r;

endmodule

// File: tb/tb_aliens_ctrl_latch.sv
// tb_aliens_ctrl_latch
// Directed bench for aliens_ctrl_latch. With ALIENS_WATCHDOG_EN defined the
// DUT gets WDOG_CYCLES = 100 and the watchdog sequence runs instead of the
// functional one.
module tb_aliens_ctrl_latch;

  localparam logic [15:0] CTRL_A = 16'h5F88;
  localparam logic [15:0] WDOG_A = 16'h5F8C;
`ifdef ALIENS_WATCHDOG_EN
  localparam int TB_WDOG = 100;
`else
  localparam int TB_WDOG = 262144;
`endif

  logic       clk;
  logic       rst_n;
  logic [4:0] bk;
  logic       woco;
  logic       rmrd;
  logic       init;
  logic [1:0] coin_cnt;
  logic [7:0] ctrl_q;

  int checks = 0;
  int errors = 0;

  aliens_ctrl_latch_if bus ();

  aliens_ctrl_latch #(
    .CTRL_ADDR   (CTRL_A),
    .WDOG_ADDR   (WDOG_A),
    .INIT_CYCLES (1024),
    .COIN_PULSE  (64),
    .WDOG_CYCLES (TB_WDOG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .bk       (bk),
    .woco     (woco),
    .rmrd     (rmrd),
    .init     (init),
    .coin_cnt (coin_cnt),
    .ctrl_q   (ctrl_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; one-cycle strobe, returns at the negedge after the write edge.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.rw   = 1'b0;
    bus.as_n = 1'b0;
    @(negedge clk);
    bus.as_n = 1'b1;
    bus.rw   = 1'b1;
  endtask

  initial begin
    int hi0;
    int hi1;
    int cnt;
    int lows;
    logic [7:0] mid_ctrl;

    bus.as_n = 1'b1;
    bus.rw = 1'b1;
    bus.addr = 16'h0000;
    bus.din = 8'h00;
    bus.bank_wr = 1'b0;
    bus.bank_d = 5'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl_q", 32'(ctrl_q), 32'h00);
    chk("rst_bk", 32'(bk), 32'h00);
    chk("rst_woco_rmrd", 32'({woco, rmrd}), 32'h0);
    chk("rst_init", 32'(init), 32'h0);
    chk("rst_coin", 32'(coin_cnt), 32'h0);

    // Init window: low for exactly 1024 edges after release.
    rst_n = 1'b1;
    repeat (1023) @(negedge clk);
    chk("init_low_1023", 32'(init), 32'h0);
    @(negedge clk);
    chk("init_high_1024", 32'(init), 32'h1);
    chk("post_init_outputs", 32'({ctrl_q, bk, woco, rmrd, coin_cnt}), 32'h0);

`ifdef ALIENS_WATCHDOG_EN
    // No kicks: bite 100 cycles after init rose; a control/bank write lands before it.
    cnt = 0;
    mid_ctrl = 8'h00;
    while (init && cnt < 500) begin
      if (cnt == 5) begin
        bus.addr = CTRL_A;
        bus.din = 8'h61;
        bus.rw = 1'b0;
        bus.as_n = 1'b0;
        bus.bank_wr = 1'b1;
        bus.bank_d = 5'h13;
      end else begin
        bus.as_n = 1'b1;
        bus.rw = 1'b1;
        bus.bank_wr = 1'b0;
      end
      @(negedge clk);
      cnt++;
      if (cnt == 50) mid_ctrl = ctrl_q;
    end
    bus.as_n = 1'b1;
    bus.rw = 1'b1;
    bus.bank_wr = 1'b0;
    chk("wdog_bite_delay", 32'(cnt), 32'd100);
    chk("wdog_ctrl_before_bite", 32'(mid_ctrl), 32'h61);
    chk("wdog_bite_ctrl_q", 32'(ctrl_q), 32'h00);
    chk("wdog_bite_bk", 32'(bk), 32'h00);
    chk("wdog_bite_coin", 32'(coin_cnt), 32'h0);
    chk("wdog_bite_init", 32'(init), 32'h0);

    // Re-init after bite, then kick every 50 cycles: init must stay high.
    repeat (1023) @(negedge clk);
    chk("wdog_reinit_low", 32'(init), 32'h0);
    @(negedge clk);
    chk("wdog_reinit_high", 32'(init), 32'h1);
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      bus.addr = WDOG_A;
      bus.din = 8'h00;
      bus.rw = 1'b0;
      bus.as_n = ((i % 50) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (!init) lows++;
    end
    bus.as_n = 1'b1;
    bus.rw = 1'b1;
    chk("wdog_kicked_init_lows", 32'(lows), 32'd0);
`else
    // Control write 0x61, bit 0 cleared 10 cycles later: pulse still 64 cycles.
    cpu_write(CTRL_A, 8'h61);
    chk("ctrl_q_61", 32'(ctrl_q), 32'h61);
    chk("woco_61", 32'(woco), 32'h1);
    chk("rmrd_61", 32'(rmrd), 32'h1);
    hi0 = 0;
    hi1 = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 10) begin
        bus.addr = CTRL_A;
        bus.din = 8'h60;
        bus.rw = 1'b0;
        bus.as_n = 1'b0;
      end else begin
        bus.as_n = 1'b1;
        bus.rw = 1'b1;
      end
      @(negedge clk);
      if (coin_cnt[0]) hi0++;
      if (coin_cnt[1]) hi1++;
    end
    bus.as_n = 1'b1;
    bus.rw = 1'b1;
    chk("coin0_pulse_len", 32'(hi0), 32'd64);
    chk("coin1_quiet", 32'(hi1), 32'd0);
    chk("ctrl_q_60", 32'(ctrl_q), 32'h60);
    chk("coin_after_pulse", 32'(coin_cnt), 32'h0);

    // Channel 1 held high: pulse then HOLD; cleared bit drops it.
    cpu_write(CTRL_A, 8'h62);
    repeat (100) @(negedge clk);
    chk("coin1_hold", 32'(coin_cnt), 32'h2);
    cpu_write(CTRL_A, 8'h60);
    @(negedge clk);
    chk("coin1_release", 32'(coin_cnt), 32'h0);

    // Bank write together with control write.
    bus.addr = CTRL_A;
    bus.din = 8'h20;
    bus.rw = 1'b0;
    bus.as_n = 1'b0;
    bus.bank_wr = 1'b1;
    bus.bank_d = 5'h13;
    @(negedge clk);
    bus.as_n = 1'b1;
    bus.rw = 1'b1;
    bus.bank_wr = 1'b0;
    chk("bank_bk", 32'(bk), 32'h13);
    chk("bank_bk4", 32'(bk[4]), 32'h1);
    chk("bank_woco", 32'(woco), 32'h1);
    chk("bank_ctrl_q", 32'(ctrl_q), 32'h20);
    chk("bank_rmrd", 32'(rmrd), 32'h0);

    // Read at CTRL_ADDR with din = FF: no change.
    bus.addr = CTRL_A;
    bus.din = 8'hFF;
    bus.rw = 1'b1;
    bus.as_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.as_n = 1'b1;
    @(negedge clk);
    chk("read_no_change", 32'({ctrl_q, bk}), 32'({8'h20, 5'h13}));

    // Write to neighbouring address: no change.
    cpu_write(16'h5F89, 8'hFF);
    chk("other_addr_no_change", 32'(ctrl_q), 32'h20);

    // Strobe held low while address moves onto CTRL_ADDR: no second write.
    bus.addr = 16'h5F89;
    bus.din = 8'hFF;
    bus.rw = 1'b0;
    bus.as_n = 1'b0;
    @(negedge clk);
    bus.addr = CTRL_A;
    repeat (3) @(negedge clk);
    bus.as_n = 1'b1;
    bus.rw = 1'b1;
    @(negedge clk);
    chk("held_strobe_no_write", 32'(ctrl_q), 32'h20);

    // Watchdog address ignored; init never falls.
    cpu_write(WDOG_A, 8'hFF);
    chk("wdog_addr_ignored", 32'(ctrl_q), 32'h20);
    repeat (300) @(negedge clk);
    chk("init_stays_high", 32'(init), 32'h1);

    // Reset mid-pulse clears asynchronously, then init restarts.
    cpu_write(CTRL_A, 8'h01);
    repeat (20) @(negedge clk);
    chk("mid_pulse_coin", 32'(coin_cnt), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_coin", 32'(coin_cnt), 32'h0);
    chk("async_rst_ctrl_bk", 32'({ctrl_q, bk}), 32'h0);
    chk("async_rst_init", 32'(init), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1023) @(negedge clk);
    chk("restart_init_low", 32'(init), 32'h0);
    chk("restart_coin", 32'(coin_cnt), 32'h0);
    @(negedge clk);
    chk("restart_init_high", 32'(init), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aliens_ctrl_latch.md
ALIENS_CTRL_LATCH -- requirements
Module: aliens_ctrl_latch

Interface
REQ-001 SHALL have parameter CTRL_ADDR, default 16'h5F88, control register write address.
REQ-002 SHALL have parameter WDOG_ADDR, default 16'h5F8C, watchdog kick address.
REQ-003 SHALL have parameter INIT_CYCLES, default 1024, INIT low time after reset or watchdog bite.
REQ-004 SHALL have parameter COIN_PULSE, default 64, minimum coin counter pulse in clk cycles.
REQ-005 SHALL have parameter WDOG_CYCLES, default 262144, watchdog timeout in clk cycles.
REQ-006 clk  in  1  single system clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 as_n  in  1  CPU address strobe, active-low, synchronous to clk.
REQ-009 rw  in  1  1 = read, 0 = write.
REQ-010 addr  in  16  CPU address.
REQ-011 din  in  8  CPU write data.
REQ-012 bank_wr  in  1  one-cycle strobe from the CPU bank-line output.
REQ-013 bank_d  in  5  ROM bank value, captured on bank_wr.
REQ-014 bk  out  5  registered ROM bank; bk[4] drives the BK4 input of the address decoder.
REQ-015 woco  out  1  work/colour RAM select (control bit 5), drives WOCO of the decoder.
REQ-016 rmrd  out  1  tilemap ROM readback (control bit 6).
REQ-017 init  out  1  INIT to the decoder; 0 during the init window, 1 otherwise.
REQ-018 coin_cnt  out  2  stretched coin counter drives.
REQ-019 ctrl_q  out  8  full latched control byte.

Function
REQ-020 Write cycle SHALL be the cycle where as_n is 0 and as_n was 1 the previous cycle (registered falling edge), with rw = 0; at most one write per strobe.
REQ-021 Write cycle with addr == CTRL_ADDR SHALL load ctrl_q <= din; woco, rmrd SHALL track ctrl_q[5], ctrl_q[6] in the same cycle.
REQ-022 bank_wr = 1 SHALL load bk <= bank_d next edge; bank_wr and a control write in the same cycle SHALL both take effect.
REQ-023 Reads, writes to other addresses and held-low as_n SHALL change no state.
REQ-024 Per coin channel n: FSM IDLE -> PULSE on ctrl_q[n] 0->1; PULSE counts COIN_PULSE cycles with coin_cnt[n] = 1; then HOLD while ctrl_q[n] = 1 (coin_cnt[n] stays 1), IDLE when ctrl_q[n] = 0 (coin_cnt[n] = 0).
REQ-025 ctrl_q[n] cleared during PULSE SHALL NOT shorten the pulse; PULSE then exits directly to IDLE.
REQ-026 Init counter SHALL hold init = 0 for exactly INIT_CYCLES cycles after reset release, then init = 1 permanently until reset or bite.
REQ-027 Counters SHALL saturate, never wrap.

Reset
REQ-028 rst_n = 0 SHALL asynchronously force ctrl_q = 0, bk = 0, woco = 0, rmrd = 0, coin_cnt = 0, init = 0, coin FSMs IDLE, all counters 0.
REQ-029 Reset mid-pulse or mid-init SHALL abort it; the sequence restarts from REQ-026 after release.

Configuration
REQ-030 With ALIENS_WATCHDOG_EN defined: watchdog counter increments while init = 1; write cycle to WDOG_ADDR clears it; reaching WDOG_CYCLES SHALL bite: init = 0 for INIT_CYCLES, ctrl_q and bk cleared, coin FSMs IDLE, counter cleared.
REQ-031 Without ALIENS_WATCHDOG_EN: no watchdog logic; WDOG_ADDR writes ignored; init never falls after first rising.

Structure
REQ-032 Shared package aliens_pkg SHALL hold coin FSM state typedef (IDLE, PULSE, HOLD) and default address constants.
REQ-033 Coin stretcher SHALL be sub-module aliens_coin_stretch, instantiated twice.

Verification
REQ-034 Reset release -> init 0 for 1024 cycles, 1 at cycle 1024; all other outputs 0.
REQ-035 Write 8'h61 to 16'h5F88 -> ctrl_q = 8'h61, woco = 1, rmrd = 1, coin_cnt[0] high exactly 64 cycles after din bit 0 cleared at cycle 10.
REQ-036 bank_wr with bank_d = 5'h13 plus simultaneous control write 8'h20 -> bk = 5'h13, bk[4] = 1, woco = 1 next edge.
REQ-037 Read (rw = 1) at 16'h5F88 with din = 8'hFF, and write to 16'h5F89 -> no output change.
REQ-038 ALIENS_WATCHDOG_EN, WDOG_CYCLES = 100, no kicks -> init falls 100 cycles after rising, ctrl_q = 0, bk = 0; kicks every 50 cycles -> init stays 1.
REQ-039 rst_n asserted mid coin pulse -> coin_cnt = 0 immediately, without clk edge.
